// File: rtl/stack_param.sv
// stack_param: parametrised LIFO stack with occupancy status, a peek of the
// top entry, sticky overflow/underflow flags and a push+pop "replace top" op.
// The write pointer equals count, so entry [count-1] is always the top.
module stack_param #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear_err,
  output logic [WIDTH-1:0] data_out,
  output logic             pop_valid,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  logic             ovf_evt;
  logic             udf_evt;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign top   = empty ? '0 : mem[top_idx];

  // Pick the write slot: the top entry on a replace, otherwise the next free slot.
  always_comb begin
    top_idx = AW'(count - CNT_W'(1));
    wr_idx  = AW'(count);
    wr_en   = 1'b0;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (!reset) begin
      if (push && pop && !empty) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (push && !full) begin
        wr_en = 1'b1;
      end
      ovf_evt = push && !pop && full;
      udf_evt = pop && empty;
    end
  end

  // Storage array; deliberately not reset, the empty count masks stale data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= data_in;
    end
  end

  // Occupancy, pop output register and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      data_out  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      // A new error on the same edge as clear_err keeps the flag set.
      overflow  <= ovf_evt || (overflow && !clear_err);
      underflow <= udf_evt || (underflow && !clear_err);
      unique case ({push, pop})
        2'b10: begin
          if (!full) begin
            count <= count + CNT_W'(1);
          end
        end
        2'b01: begin
          if (!empty) begin
            data_out  <= mem[top_idx];
            pop_valid <= 1'b1;
            count     <= count - CNT_W'(1);
          end
        end
        2'b11: begin
          if (!empty) begin
            data_out  <= mem[top_idx];
            pop_valid <= 1'b1;
          end else begin
            count <= CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/stack_param.md
Name: stack_param

Overview:
- Parametrised LIFO stack, generalising the team's fixed 8-bit x 16-entry stack.
- Configurable data width and depth; full/empty/occupancy status; a combinational peek of the top entry.
- Separate sticky overflow and underflow flags with a clear input; defined push+pop "replace top" operation.
- Sits between a producer/consumer pair in the datapath; single clock domain.

Parameters:
- WIDTH, 8: data word width in bits (>=1).
- DEPTH, 16: number of entries (>=2, need not be a power of two).
- CNT_W, $clog2(DEPTH+1): width of the occupancy count (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write data_in onto the stack this cycle.
- pop  input  1  remove the top entry this cycle.
- data_in  input  WIDTH  word to push.
- clear_err  input  1  clears both sticky error flags.
- data_out  output  WIDTH  registered copy of the last popped word.
- pop_valid  output  1  one-cycle pulse; data_out was updated by a successful pop.
- top  output  WIDTH  combinational view of the current top entry; 0 when empty.
- count  output  CNT_W  current number of stored entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a push was rejected.
- underflow  output  1  sticky; a pop was rejected.

Behaviour:
- Inputs are sampled directly at each rising edge, with no input register stage. All state updates at that same edge.
- Reset (synchronous, highest priority, overrides any simultaneous push, pop or clear_err):
  - count=0, data_out=0, pop_valid=0, overflow=0, underflow=0.
  - Storage contents are not reset; top reads 0 because the stack is empty.
- Storage: array of DEPTH words. Pointer equals count. Entry [count-1] is the top. The pointer never wraps; bounds are enforced by the rules below.
- Operation per edge, reset low:
  - push only, not full: mem[count] <= data_in; count+1.
  - push only, full: no write; count unchanged; overflow <= 1.
  - pop only, not empty: data_out <= mem[count-1]; pop_valid <= 1; count-1.
  - pop only, empty: data_out unchanged; pop_valid <= 0; underflow <= 1.
  - push+pop, not empty (includes full) — replace top:
    - data_out <= old mem[count-1]; pop_valid <= 1.
    - mem[count-1] <= data_in; count unchanged; no error.
  - push+pop, empty: push is performed (mem[0] <= data_in, count=1); the pop is rejected (underflow <= 1, pop_valid <= 0).
  - neither: state holds; pop_valid <= 0.
- pop_valid is high for exactly the one cycle following each successful pop edge.
- Latency:
  - Popped data appears on data_out one edge after pop is sampled.
  - top, full, empty and count reflect the post-edge state immediately; no extra cycle.
- Error flags:
  - Set on the offending edge and stay set until clear_err or reset.
  - If clear_err coincides with a new error event, the set wins (flag stays 1).
- count width: arithmetic is done at CNT_W bits. DEPTH=16 gives CNT_W=5, range 0..16.
- Synthesis: no latches; all combinational paths fully assigned.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 -> count=3, top=0x33. Three pops -> data_out 0x33, 0x22, 0x11, each with a one-cycle pop_valid; then empty=1, top=0.
- Fill DEPTH=16 with 0x00..0x0F -> full=1. 17th push of 0xAA -> overflow=1, count=16, top=0x0F. clear_err -> overflow=0.
- Pop on empty after reset -> underflow=1, pop_valid=0, data_out=0, count=0.
- Stack holds [0x01, 0x02], then push+pop with data_in=0x55 -> data_out=0x02, pop_valid=1, count=2, top=0x55.
- Push+pop on empty with data_in=0x77 -> count=1, top=0x77, underflow=1, pop_valid=0. Repeat push+pop while full -> count=16, no overflow.
- Assert reset with 5 entries stored and push high on the same edge -> count=0, empty=1, errors=0, pop_valid=0. Also re-run the first scenario with WIDTH=12, DEPTH=5 -> CNT_W=3, full at count=5.
